pipe_array_mult: RTL and testbench

Parametrised, pipelined array multiplier for signed (two's complement) or unsigned operands, chosen per transaction. It accepts one operand pair per cycle and returns the full-width product after a fixed latency. Valid/ready handshakes on both sides carry backpressure. It is the clocked, streaming successor to the team's combinational 8x8 signed array multiplier, and sits between operand producers and the accumulate/datapath logic.

---
 rtl/pipe_array_mult.sv | 98 +++++++++
 tb/tb_pipe_array_mult.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_array_mult.sv
// Pipelined Baugh-Wooley array multiplier with valid/ready handshakes.
// Each stage folds ROWS_PER_STAGE partial-product rows into a running 2*WIDTH sum.
module pipe_array_mult #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned ROWS_PER_STAGE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_signed,
  output logic               busy
);

  localparam int unsigned STAGES = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
  localparam int unsigned PW     = 2 * WIDTH;
  localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  // Row i of the partial-product array; in signed mode the bits where exactly one of
  // (row, column) is the MSB are inverted, completed by BW_CONST.
  function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] x, input logic yb,
                                           input int unsigned i, input logic sgn);
    logic [PW-1:0] row;
    logic          b;
    row = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      b = x[j] & yb;
      if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) b = ~b;
      row = row | (PW'(b) << (i + j));
    end
    return row;
  endfunction

  logic [STAGES-1:0]            vld_q;
  logic [STAGES-1:0]            sgn_q;
  logic [STAGES-1:0][WIDTH-1:0] x_q;
  logic [STAGES-1:0][WIDTH-1:0] y_q;
  logic [STAGES-1:0][PW-1:0]    sum_q;
  logic [STAGES-1:0][PW-1:0]    sum_d;
  logic                         stall;

  assign stall      = vld_q[STAGES-1] && !out_ready;
  assign in_ready   = !stall;
  assign out_valid  = vld_q[STAGES-1];
  assign out_p      = sum_q[STAGES-1];
  assign out_signed = sgn_q[STAGES-1];
  assign busy       = |vld_q;

  always_comb begin
    sum_d = '0;
    sum_d[0] = in_signed ? BW_CONST : '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i / ROWS_PER_STAGE == 0) sum_d[0] = sum_d[0] + pp_row(in_x, in_y[i], i, in_signed);
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      sum_d[k] = sum_q[k-1];
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (i / ROWS_PER_STAGE == k) begin
          sum_d[k] = sum_d[k] + pp_row(x_q[k-1], y_q[k-1][i], i, sgn_q[k-1]);
        end
      end
    end
  end

  // Bubbles travel with the pipeline; everything freezes together on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sgn_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      sum_q <= '0;
    end else if (!stall) begin
      vld_q[0] <= in_valid;
      sgn_q[0] <= in_signed;
      x_q[0]   <= in_x;
      y_q[0]   <= in_y;
      sum_q[0] <= sum_d[0];
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        sgn_q[k] <= sgn_q[k-1];
        x_q[k]   <= x_q[k-1];
        y_q[k]   <= y_q[k-1];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  logic unused_last;
  assign unused_last = ^{x_q[STAGES-1], y_q[STAGES-1]};

endmodule

// File: tb/tb_pipe_array_mult.sv
// Directed and scoreboarded checks of pipe_array_mult at 8x8/2 rows and 16x16/3 rows.
module tb_pipe_array_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        v8, rdy8, s8, ov8, ordy8, os8, busy8;
  logic [7:0]  x8, y8;
  logic [15:0] p8;
  logic        v16, rdy16, s16, ov16, ordy16, os16, busy16;
  logic [15:0] x16, y16;
  logic [31:0] p16;

  pipe_array_mult #(.WIDTH(8), .ROWS_PER_STAGE(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_x(x8), .in_y(y8),
    .in_signed(s8), .out_valid(ov8), .out_ready(ordy8), .out_p(p8), .out_signed(os8),
    .busy(busy8)
  );

  pipe_array_mult #(.WIDTH(16), .ROWS_PER_STAGE(3)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .in_x(x16), .in_y(y16),
    .in_signed(s16), .out_valid(ov16), .out_ready(ordy16), .out_p(p16), .out_signed(os16),
    .busy(busy16)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] q8[$];
  logic [32:0] q16[$];
  logic [16:0] e8;
  logic [32:0] e16;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y,
                                         input logic s);
    logic signed [15:0] a, b;
    logic [15:0] ua, ub;
    a = $signed(x); b = $signed(y); ua = {8'h0, x}; ub = {8'h0, y};
    return s ? a * b : ua * ub;
  endfunction

  function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic s);
    logic signed [31:0] a, b;
    logic [31:0] ua, ub;
    a = $signed(x); b = $signed(y); ua = {16'h0, x}; ub = {16'h0, y};
    return s ? a * b : ua * ub;
  endfunction

  // Handoffs are decided at the coming edge, so look at them half a cycle earlier.
  always @(negedge clk) begin
    if (rst_n && ov8 && ordy8) begin
      if (q8.size() == 0) check("dut8 spurious out_valid", ov8, 1'b0);
      else begin
        e8 = q8.pop_front();
        check("dut8 out_p", p8, e8[15:0]);
        check("dut8 out_signed", os8, e8[16]);
      end
    end
    if (rst_n && ov16 && ordy16) begin
      if (q16.size() == 0) check("dut16 spurious out_valid", ov16, 1'b0);
      else begin
        e16 = q16.pop_front();
        check("dut16 out_p", p16, e16[31:0]);
        check("dut16 out_signed", os16, e16[32]);
      end
    end
  end

  // Called and returns at #1 after a rising edge; returns just after the accepting edge.
  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic s,
                       input logic [15:0] e);
    bit acc;
    int guard;
    x8 = x; y8 = y; s8 = s; v8 = 1'b1; q8.push_back({s, e}); guard = 0;
    do begin
      @(negedge clk); acc = rdy8; @(posedge clk); #1; guard++;
    end while (!acc && guard < 200);
    if (!acc) check("dut8 accept timeout", acc, 1'b1);
    v8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input logic [31:0] e);
    bit acc;
    int guard;
    x16 = x; y16 = y; s16 = s; v16 = 1'b1; q16.push_back({s, e}); guard = 0;
    do begin
      @(negedge clk); acc = rdy16; @(posedge clk); #1; guard++;
    end while (!acc && guard < 200);
    if (!acc) check("dut16 accept timeout", acc, 1'b1);
    v16 = 1'b0;
  endtask

  task automatic drain8();
    int g = 0;
    while (q8.size() != 0 && g < 100) begin @(posedge clk); #1; g++; end
    check("dut8 drain", q8.size(), 0);
  endtask

  task automatic drain16();
    int g = 0;
    while (q16.size() != 0 && g < 100) begin @(posedge clk); #1; g++; end
    check("dut16 drain", q16.size(), 0);
  endtask

  // Counts edges from the accepting edge (inclusive) until out_valid shows.
  task automatic latency8(input int exp);
    int cnt = 1;
    while (!ov8 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    check("dut8 latency", cnt, exp);
  endtask

  task automatic latency16(input int exp);
    int cnt = 1;
    while (!ov16 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    check("dut16 latency", cnt, exp);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rx [10];
    logic [7:0]  ry [10];
    logic        rs [10];
    logic [15:0] hold_p;
    logic [15:0] a16, b16;
    logic        m16;

    rst_n = 1'b0;
    v8 = 0; x8 = 0; y8 = 0; s8 = 0; ordy8 = 1;
    v16 = 0; x16 = 0; y16 = 0; s16 = 0; ordy16 = 1;
    #12;
    check("reset out_valid", ov8, 1'b0);
    check("reset out_p", p8, 16'h0);
    check("reset out_signed", os8, 1'b0);
    check("reset busy", busy8, 1'b0);
    check("reset in_ready", rdy8, 1'b1);
    check("reset dut16 out_valid", ov16, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", rdy8, 1'b1);

    send8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    latency8(4);
    drain8();

    send8(8'hFF, 8'hFF, 1'b1, 16'h0001);
    send8(8'h80, 8'h80, 1'b1, 16'h4000);
    send8(8'h80, 8'h7F, 1'b1, 16'hC080);
    send8(8'h05, 8'hFD, 1'b1, 16'hFFF1);
    check("signed stream first valid", ov8, 1'b1);
    repeat (3) begin @(posedge clk); #1; check("signed stream back-to-back", ov8, 1'b1); end
    drain8();

    repeat (2) begin
      send8(8'hFF, 8'h02, 1'b0, 16'h01FE);
      send8(8'hFF, 8'h02, 1'b1, 16'hFFFE);
    end
    drain8();

    for (int i = 0; i < 10; i++) begin
      rx[i] = 8'($urandom); ry[i] = 8'($urandom); rs[i] = 1'($urandom);
    end
    for (int i = 0; i < 5; i++) send8(rx[i], ry[i], rs[i], model8(rx[i], ry[i], rs[i]));
    ordy8 = 1'b0;
    hold_p = p8;
    check("stall out_valid", ov8, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("stall in_ready", rdy8, 1'b0);
      check("stall out_p hold", p8, hold_p);
      check("stall out_valid hold", ov8, 1'b1);
    end
    ordy8 = 1'b1;
    for (int i = 5; i < 10; i++) send8(rx[i], ry[i], rs[i], model8(rx[i], ry[i], rs[i]));
    drain8();

    send8(8'd7, 8'd9, 1'b0, 16'd63);
    send8(8'hF0, 8'h11, 1'b1, 16'hFEF0);
    send8(8'd12, 8'd12, 1'b0, 16'd144);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", ov8, 1'b0);
    check("mid reset busy", busy8, 1'b0);
    check("mid reset in_ready", rdy8, 1'b1);
    check("mid reset out_p", p8, 16'h0);
    q8.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; check("no stale after reset", ov8, 1'b0); end
    send8(8'd3, 8'd5, 1'b0, 16'h000F);
    latency8(4);
    drain8();

    send16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    latency16(6);
    drain16();
    for (int i = 0; i < 10000; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); m16 = 1'(i);
      send16(a16, b16, m16, model16(a16, b16, m16));
    end
    drain16();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
